// File: rtl/btn_step_pkg.sv
// Shared types and constants for the button front end: channel FSM states,
// default timing for a 100 MHz clock and the Nexys A7 button bit positions.
package btn_step_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    localparam int          DEF_N_BTN           = 5;
    localparam int          DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int          DEF_REPEAT_DELAY    = 50000000;
    localparam int          DEF_REPEAT_PERIOD   = 10000000;
    localparam logic [4:0]  DEF_REPEAT_MASK     = 5'b10000;

    localparam int BTN_U = 4;
    localparam int BTN_L = 3;
    localparam int BTN_C = 2;
    localparam int BTN_R = 1;
    localparam int BTN_D = 0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_step_ctrl_channel.sv
// One button: 2-flop synchroniser, debounce counter, press/release pulse FSM
// and a shared delay/period counter for auto-repeat.
module btn_channel
    import btn_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE     = DW'(1);
    localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] REP_ONE     = RW'(1);

    logic [1:0]    sync_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          level_q, level_d;
    btn_state_e    state_q, state_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          rise, fall;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q    <= '0;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            state_q   <= IDLE;
            rep_cnt_q <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // The level only flips once the synchronised input has disagreed with it
    // for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        if (sync_q[1] == level_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            level_d   = ~level_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = HELD;
            HELD: begin
                if (fall)                                  state_d = IDLE;
                else if (REPEAT_EN && rep_cnt_q == '0)     state_d = REPEAT;
            end
            REPEAT:  if (fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Release has priority over a repeat pulse falling due in the same cycle.
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        rep_cnt_d = rep_cnt_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d   = 1'b1;
                    rep_cnt_d = DELAY_LOAD;
                end
            end
            HELD, REPEAT: begin
                if (fall) begin
                    release_d = 1'b1;
                end else if (rep_cnt_q == '0) begin
                    if (REPEAT_EN) begin
                        press_d   = 1'b1;
                        rep_cnt_d = PERIOD_LOAD;
                    end
                end else begin
                    rep_cnt_d = rep_cnt_q - REP_ONE;
                end
            end
            default: ;
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_step_ctrl.sv
// Button front end for the Nexys A7: one independent debounce/repeat channel
// per button, bit order {U, L, C, R, D}.
module btn_step_ctrl
    import btn_step_pkg::*;
#(
    parameter int               N_BTN           = DEF_N_BTN,
    parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int               REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int               REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(DEF_REPEAT_MASK)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[g])
        ) u_chan (
            .clk_i     (clk),
            .reset_i   (reset),
            .btn_i     (btn_in[g]),
            .level_o   (btn_level[g]),
            .press_o   (btn_press[g]),
            .release_o (btn_release[g])
        );
    end

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Bench for btn_step_ctrl with short timing: DEBOUNCE 4, DELAY 20, PERIOD 8,
// repeat on channel 4 only. Expected pulse events are queued by cycle number.
module tb_btn_step_ctrl;

  localparam int         N_BTN = 5;
  localparam int         DEB   = 4;
  localparam int         RDLY  = 20;
  localparam int         RPER  = 8;
  localparam logic [4:0] RMASK = 5'b10000;
  localparam int         LAT   = 2 + DEB;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_BTN-1:0] btn_in = '0;
  logic [N_BTN-1:0] btn_level, btn_press, btn_release;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  bit  mon_en = 1'b0;
  logic [31:0] exp_q[$];

  typedef struct {
    int ch;
    int hi;
  } vec_t;

  vec_t vecs[11];

  btn_step_ctrl #(
    .N_BTN           (N_BTN),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER),
    .REPEAT_MASK     (RMASK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ev(input int c, input int t, input int ch);
    return 32'(c * 16 + t * 8 + ch);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_ev(input int c, input int t, input int ch);
    logic [31:0] v;
    int i;
    v = ev(c, t, ch);
    i = 0;
    while (i < exp_q.size() && exp_q[i] <= v) i++;
    exp_q.insert(i, v);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard: every observed pulse must be the next expected event
  always @(negedge clk) begin
    if (mon_en) begin
      for (int t = 0; t < 2; t++) begin
        for (int ch = 0; ch < N_BTN; ch++) begin
          if ((t == 0 && btn_press[ch] === 1'b1) || (t == 1 && btn_release[ch] === 1'b1)) begin
            n_checks++;
            if (exp_q.size() > 0 && exp_q[0] == ev(cyc, t, ch)) begin
              n_pass++;
              void'(exp_q.pop_front());
            end else begin
              $display("FAIL unexpected_%s: ch %0d at cycle %0d, next expected %0h",
                       (t == 0) ? "press" : "release", ch, cyc,
                       (exp_q.size() > 0) ? exp_q[0] : 32'hffffffff);
            end
          end
        end
      end
      for (int ch = 0; ch < N_BTN; ch++) begin
        if (btn_press[ch] === 1'b1 && btn_release[ch] === 1'b1)
          chk($sformatf("press_and_release_ch%0d", ch), 32'(btn_release[ch]), 32'd0);
      end
      while (exp_q.size() > 0 && int'(exp_q[0] >> 4) <= cyc) begin
        n_checks++;
        $display("FAIL missed_event: got none expected event %0h (cycle %0d)", exp_q[0], cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int c;
    vecs[0]  = '{0, 1};
    vecs[1]  = '{0, 2};
    vecs[2]  = '{0, 3};
    vecs[3]  = '{0, 4};
    vecs[4]  = '{0, 10};
    vecs[5]  = '{1, 3};
    vecs[6]  = '{1, 5};
    vecs[7]  = '{2, 4};
    vecs[8]  = '{3, 7};
    vecs[9]  = '{4, 3};
    vecs[10] = '{4, 12};

    ticks(3);
    @(negedge clk);
    chk("reset_level", 32'(btn_level), 32'd0);
    chk("reset_press", 32'(btn_press), 32'd0);
    chk("reset_release", 32'(btn_release), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    ticks(2);

    // table: pulse width vs debounce threshold, per channel
    foreach (vecs[v]) begin
      c = cyc;
      btn_in[vecs[v].ch] = 1'b1;
      if (vecs[v].hi >= DEB) begin
        push_ev(c + LAT, 0, vecs[v].ch);
        push_ev(c + vecs[v].hi + LAT, 1, vecs[v].ch);
      end
      for (int k = 1; k <= vecs[v].hi + 14; k++) begin
        @(posedge clk);
        #1;
        if (k == vecs[v].hi) btn_in[vecs[v].ch] = 1'b0;
        if (k == LAT) begin
          @(negedge clk);
          chk($sformatf("vec%0d_level", v), 32'(btn_level[vecs[v].ch]),
              32'(vecs[v].hi >= DEB));
        end
      end
      chk($sformatf("vec%0d_queue_empty", v), 32'(exp_q.size()), 32'd0);
    end

    // 1: clean press on channel 0, exact level latency
    c = cyc;
    btn_in[0] = 1'b1;
    push_ev(c + LAT, 0, 0);
    push_ev(c + 40 + LAT, 1, 0);
    ticks(LAT - 1);
    @(negedge clk);
    chk("t1_level_before", 32'(btn_level[0]), 32'd0);
    ticks(1);
    @(negedge clk);
    chk("t1_level_after", 32'(btn_level[0]), 32'd1);
    ticks(40 - LAT);
    btn_in[0] = 1'b0;
    ticks(20);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: bounce 3 high / 1 low / 3 high / 1 low then a real hold
    c = cyc;
    btn_in[0] = 1'b1; ticks(3);
    btn_in[0] = 1'b0; ticks(1);
    btn_in[0] = 1'b1; ticks(3);
    btn_in[0] = 1'b0; ticks(1);
    @(negedge clk);
    chk("t2_level_bounce", 32'(btn_level[0]), 32'd0);
    c = cyc;
    btn_in[0] = 1'b1;
    push_ev(c + LAT, 0, 0);
    push_ev(c + 10 + LAT, 1, 0);
    ticks(10);
    btn_in[0] = 1'b0;
    ticks(20);
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: auto-repeat on channel 4
    c = cyc;
    btn_in[4] = 1'b1;
    push_ev(c + LAT, 0, 4);
    for (int r = 0; r < 5; r++) push_ev(c + LAT + RDLY + r * RPER, 0, 4);
    push_ev(c + LAT + 50 + LAT, 1, 4);
    ticks(LAT + 50);
    btn_in[4] = 1'b0;
    ticks(20);
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: simultaneous press on channels 4 and 1; only 4 repeats
    c = cyc;
    btn_in = 5'b10010;
    push_ev(c + LAT, 0, 1);
    push_ev(c + LAT, 0, 4);
    push_ev(c + LAT + RDLY, 0, 4);
    push_ev(c + LAT + RDLY + RPER, 0, 4);
    push_ev(c + 30 + LAT, 1, 1);
    push_ev(c + 30 + LAT, 1, 4);
    ticks(30);
    btn_in = '0;
    ticks(20);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: reset while channel 4 is repeating, button still held
    c = cyc;
    btn_in[4] = 1'b1;
    push_ev(c + LAT, 0, 4);
    push_ev(c + LAT + RDLY, 0, 4);
    ticks(30);
    reset = 1'b1;
    ticks(1);
    @(negedge clk);
    chk("t5_reset_level", 32'(btn_level), 32'd0);
    chk("t5_reset_press", 32'(btn_press), 32'd0);
    chk("t5_reset_release", 32'(btn_release), 32'd0);
    reset = 1'b0;
    c = cyc;
    push_ev(c + LAT, 0, 4);
    push_ev(c + 9 + LAT, 1, 4);
    ticks(9);
    btn_in[4] = 1'b0;
    ticks(20);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: debounced fall lands on the second repeat cycle
    c = cyc;
    btn_in[4] = 1'b1;
    push_ev(c + LAT, 0, 4);
    push_ev(c + LAT + RDLY, 0, 4);
    push_ev(c + LAT + RDLY + RPER, 1, 4);
    ticks(LAT + RDLY + RPER - LAT);
    btn_in[4] = 1'b0;
    ticks(LAT - 1);
    @(negedge clk);
    chk("t6_level_before_fall", 32'(btn_level[4]), 32'd1);
    ticks(1);
    @(negedge clk);
    chk("t6_press_on_release", 32'(btn_press[4]), 32'd0);
    chk("t6_release", 32'(btn_release[4]), 32'd1);
    ticks(20);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
